wb_stage: RTL and testbench

- MEM/WB pipeline latch and writeback unit of the pipelined datapath; sits directly upstream of the register file.
- Captures the retiring instruction from the memory stage and selects the result: ALU result, extended load data, or link address.
- Drives the register file write port (WEN/wsel/wdat) and a matching forwarding bus back to the execute stage.
- Tracks halt and counts retired instructions.

---
 rtl/wb_stage.sv | 164 ++++++++++++++++
 tb/tb_wb_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// MEM/WB pipeline latch and writeback unit.
//
// Captures the retiring instruction from the memory stage and selects its result
// (ALU result, extended load data or link address). It drives the register file
// write port and an identical forwarding bus back to execute. It also keeps a
// sticky halt flag and counts retired instructions.
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   stall, flush        hold the latch / squash the incoming entry (flush wins)
//   mem_*               instruction fields presented by the memory stage
//   rf_wen/wsel/wdat    register file write port
//   fwd_valid/sel/dat   forwarding bus, identical to the write port
//   halt                sticky halt, set after a halt instruction retires
//   retired             retired-instruction counter (wraps)
module wb_stage #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_valid,
   input  logic             mem_regwen,
   input  logic [4:0]       mem_wsel,
   input  logic [31:0]      mem_alu,
   input  logic [31:0]      mem_dload,
   input  logic             mem_memtoreg,
   input  logic [2:0]       mem_ldtype,
   input  logic [1:0]       mem_boff,
   input  logic             mem_jal,
   input  logic [31:0]      mem_npc,
   input  logic             mem_halt,
   output logic             rf_wen,
   output logic [4:0]       rf_wsel,
   output logic [31:0]      rf_wdat,
   output logic             fwd_valid,
   output logic [4:0]       fwd_sel,
   output logic [31:0]      fwd_dat,
   output logic             halt,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] LdLw  = 3'd0;
   localparam logic [2:0] LdLb  = 3'd1;
   localparam logic [2:0] LdLbu = 3'd2;
   localparam logic [2:0] LdLh  = 3'd3;
   localparam logic [2:0] LdLhu = 3'd4;

   // MEM/WB latch
   logic        valid_q;
   logic        regwen_q;
   logic [4:0]  wsel_q;
   logic [31:0] alu_q;
   logic [31:0] dload_q;
   logic        memtoreg_q;
   logic [2:0]  ldtype_q;
   logic [1:0]  boff_q;
   logic        jal_q;
   logic [31:0] npc_q;
   logic        ihalt_q;

   // Bookkeeping state
   logic             done_q, done_d;
   logic             halt_q, halt_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic        retire;
   logic [31:0] byte_word;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   // An entry retires (and may write) only in the first cycle it is visible;
   // done_q masks it for the remainder of a stall.
   assign retire = valid_q & ~done_q & ~halt_q;

   always_comb begin
      done_d    = 1'b0;
      halt_d    = halt_q | (retire & ihalt_q);
      retired_d = retired_q;
      if (retire) begin
         retired_d = retired_q + CNT_W'(1);
      end
      if (flush) begin
         done_d = 1'b0;
      end else if (stall) begin
         done_d = done_q | valid_q;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         valid_q    <= 1'b0;
         regwen_q   <= 1'b0;
         wsel_q     <= '0;
         alu_q      <= '0;
         dload_q    <= '0;
         memtoreg_q <= 1'b0;
         ldtype_q   <= '0;
         boff_q     <= '0;
         jal_q      <= 1'b0;
         npc_q      <= '0;
         ihalt_q    <= 1'b0;
         done_q     <= 1'b0;
         halt_q     <= 1'b0;
         retired_q  <= '0;
      end else begin
         if (flush) begin
            valid_q <= 1'b0;
         end else if (!stall) begin
            valid_q    <= mem_valid;
            regwen_q   <= mem_regwen;
            wsel_q     <= mem_wsel;
            alu_q      <= mem_alu;
            dload_q    <= mem_dload;
            memtoreg_q <= mem_memtoreg;
            ldtype_q   <= mem_ldtype;
            boff_q     <= mem_boff;
            jal_q      <= mem_jal;
            npc_q      <= mem_npc;
            ihalt_q    <= mem_halt;
         end
         done_q    <= done_d;
         halt_q    <= halt_d;
         retired_q <= retired_d;
      end
   end

   // Load extension; halfwords use only boff[1], so misaligned halves fold down.
   always_comb begin
      byte_word = dload_q >> {boff_q, 3'b000};
      ld_byte   = byte_word[7:0];
      ld_half   = boff_q[1] ? dload_q[31:16] : dload_q[15:0];
      case (ldtype_q)
         LdLb:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         LdLbu:   ld_ext = {24'h0, ld_byte};
         LdLh:    ld_ext = {{16{ld_half[15]}}, ld_half};
         LdLhu:   ld_ext = {16'h0, ld_half};
         LdLw:    ld_ext = dload_q;
         default: ld_ext = dload_q;
      endcase
   end

   always_comb begin
      rf_wsel = jal_q ? 5'd31 : wsel_q;
      if (jal_q) begin
         rf_wdat = npc_q;
      end else if (memtoreg_q) begin
         rf_wdat = ld_ext;
      end else begin
         rf_wdat = alu_q;
      end
      // The halt instruction itself never writes.
      rf_wen = retire & regwen_q & ~ihalt_q & (rf_wsel != 5'd0);
   end

   assign fwd_valid = rf_wen;
   assign fwd_sel   = rf_wsel;
   assign fwd_dat   = rf_wdat;
   assign halt      = halt_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        stall, flush;
   logic        mem_valid, mem_regwen, mem_memtoreg, mem_jal, mem_halt;
   logic [4:0]  mem_wsel;
   logic [31:0] mem_alu, mem_dload, mem_npc;
   logic [2:0]  mem_ldtype;
   logic [1:0]  mem_boff;
   logic        rf_wen, fwd_valid, halt;
   logic [4:0]  rf_wsel, fwd_sel;
   logic [31:0] rf_wdat, fwd_dat;
   logic [31:0] retired;

   int n_chk  = 0;
   int n_pass = 0;

   logic [36:0] sb_q[$];

   wb_stage #(.CNT_W(32)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .stall        (stall),
      .flush        (flush),
      .mem_valid    (mem_valid),
      .mem_regwen   (mem_regwen),
      .mem_wsel     (mem_wsel),
      .mem_alu      (mem_alu),
      .mem_dload    (mem_dload),
      .mem_memtoreg (mem_memtoreg),
      .mem_ldtype   (mem_ldtype),
      .mem_boff     (mem_boff),
      .mem_jal      (mem_jal),
      .mem_npc      (mem_npc),
      .mem_halt     (mem_halt),
      .rf_wen       (rf_wen),
      .rf_wsel      (rf_wsel),
      .rf_wdat      (rf_wdat),
      .fwd_valid    (fwd_valid),
      .fwd_sel      (fwd_sel),
      .fwd_dat      (fwd_dat),
      .halt         (halt),
      .retired      (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Write-port scoreboard: every observed write must match the oldest expected one.
   always @(negedge clk) begin
      if (n_rst === 1'b1) begin
         if (rf_wen === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("unexpected_write", {27'h0, rf_wsel}, 32'hffff_ffff);
            end else begin
               logic [36:0] e;
               e = sb_q.pop_front();
               check("rf_wsel", {27'h0, rf_wsel}, {27'h0, e[36:32]});
               check("rf_wdat", rf_wdat, e[31:0]);
               check("fwd_valid", {31'h0, fwd_valid}, 32'd1);
               check("fwd_sel", {27'h0, fwd_sel}, {27'h0, e[36:32]});
               check("fwd_dat", fwd_dat, e[31:0]);
            end
         end else begin
            check("fwd_valid_idle", {31'h0, fwd_valid}, 32'd0);
         end
      end
   end

   task automatic idle();
      mem_valid = 1'b0; mem_regwen = 1'b0; mem_wsel = '0; mem_alu = '0; mem_dload = '0;
      mem_memtoreg = 1'b0; mem_ldtype = '0; mem_boff = '0; mem_jal = 1'b0; mem_npc = '0;
      mem_halt = 1'b0;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Present one MEM entry for one cycle; push its expected write if any.
   task automatic issue(input logic rw, input logic [4:0] ws, input logic [31:0] alu,
                        input logic [31:0] dl, input logic m2r, input logic [2:0] ld,
                        input logic [1:0] bo, input logic jal, input logic [31:0] npc,
                        input logic h, input logic exp_wr, input logic [4:0] exp_sel,
                        input logic [31:0] exp_dat);
      mem_valid = 1'b1; mem_regwen = rw; mem_wsel = ws; mem_alu = alu; mem_dload = dl;
      mem_memtoreg = m2r; mem_ldtype = ld; mem_boff = bo; mem_jal = jal; mem_npc = npc;
      mem_halt = h;
      if (exp_wr) sb_q.push_back({exp_sel, exp_dat});
      cycles(1);
      idle();
   endtask

   initial begin
      n_rst = 1'b0; stall = 1'b0; flush = 1'b0;
      idle();
      #2;
      check("rst_wen", {31'h0, rf_wen}, 32'd0);
      check("rst_wsel", {27'h0, rf_wsel}, 32'd0);
      check("rst_wdat", rf_wdat, 32'd0);
      check("rst_halt", {31'h0, halt}, 32'd0);
      check("rst_retired", retired, 32'd0);
      cycles(2);
      n_rst = 1'b1;
      cycles(1);

      // ALU writeback
      issue(1, 5'd5, 32'h1234_5678, 32'h0, 0, 3'd0, 2'd0, 0, 32'h0, 0, 1, 5'd5, 32'h1234_5678);
      check("retired_before", retired, 32'd0);
      cycles(1);
      check("retired_alu", retired, 32'd1);

      // Load extension, dload = 0x80FF7F01
      issue(1, 5'd1, 32'hdead, 32'h80FF_7F01, 1, 3'd1, 2'd2, 0, 32'h0, 0, 1, 5'd1, 32'hFFFF_FFFF);
      issue(1, 5'd2, 32'hdead, 32'h80FF_7F01, 1, 3'd2, 2'd3, 0, 32'h0, 0, 1, 5'd2, 32'h0000_0080);
      issue(1, 5'd3, 32'hdead, 32'h80FF_7F01, 1, 3'd3, 2'd2, 0, 32'h0, 0, 1, 5'd3, 32'hFFFF_80FF);
      issue(1, 5'd4, 32'hdead, 32'h80FF_7F01, 1, 3'd4, 2'd0, 0, 32'h0, 0, 1, 5'd4, 32'h0000_7F01);
      issue(1, 5'd6, 32'hdead, 32'h80FF_7F01, 1, 3'd0, 2'd1, 0, 32'h0, 0, 1, 5'd6, 32'h80FF_7F01);
      issue(1, 5'd8, 32'hdead, 32'h80FF_7F01, 1, 3'd6, 2'd0, 0, 32'h0, 0, 1, 5'd8, 32'h80FF_7F01);

      // JAL forces r31 and npc; r0 write suppressed but retires
      issue(1, 5'd7, 32'hbeef, 32'h0, 1, 3'd0, 2'd0, 1, 32'h44, 0, 1, 5'd31, 32'h0000_0044);
      issue(1, 5'd0, 32'h99, 32'h0, 0, 3'd0, 2'd0, 0, 32'h0, 0, 0, 5'd0, 32'h0);
      cycles(1);
      check("retired_jal_r0", retired, 32'd9);

      // Three-cycle stall: exactly one write and one retire
      issue(1, 5'd9, 32'hAAAA, 32'h0, 0, 3'd0, 2'd0, 0, 32'h0, 0, 1, 5'd9, 32'h0000_AAAA);
      stall = 1'b1;
      mem_valid = 1'b1; mem_regwen = 1'b1; mem_wsel = 5'd10; mem_alu = 32'h5555;
      cycles(3);
      check("stall_hold_wen", {31'h0, rf_wen}, 32'd0);
      stall = 1'b0;
      idle();
      cycles(1);
      check("retired_stall", retired, 32'd10);

      // Flush beats stall: entry becomes a bubble
      stall = 1'b1; flush = 1'b1;
      issue(1, 5'd11, 32'hBBBB, 32'h0, 0, 3'd0, 2'd0, 0, 32'h0, 0, 0, 5'd0, 32'h0);
      check("flush_wen", {31'h0, rf_wen}, 32'd0);
      stall = 1'b0; flush = 1'b0;
      cycles(2);
      check("retired_flush", retired, 32'd10);

      // Halt: sticky, no write, later entries neither write nor retire
      issue(0, 5'd0, 32'h0, 32'h0, 0, 3'd0, 2'd0, 0, 32'h0, 1, 0, 5'd0, 32'h0);
      check("halt_not_yet", {31'h0, halt}, 32'd0);
      issue(1, 5'd12, 32'hC0DE, 32'h0, 0, 3'd0, 2'd0, 0, 32'h0, 0, 0, 5'd0, 32'h0);
      check("halt_set", {31'h0, halt}, 32'd1);
      issue(1, 5'd13, 32'hC0DF, 32'h0, 0, 3'd0, 2'd0, 0, 32'h0, 0, 0, 5'd0, 32'h0);
      cycles(3);
      check("halt_held", {31'h0, halt}, 32'd1);
      check("retired_halt", retired, 32'd11);

      // Reset clears halt and counter
      n_rst = 1'b0;
      #1;
      check("rst2_halt", {31'h0, halt}, 32'd0);
      check("rst2_retired", retired, 32'd0);
      cycles(1);
      n_rst = 1'b1;
      cycles(1);

      // Reset while an entry is pending in a stall: discarded, never rewritten
      issue(1, 5'd14, 32'hCCCC, 32'h0, 0, 3'd0, 2'd0, 0, 32'h0, 0, 1, 5'd14, 32'h0000_CCCC);
      stall = 1'b1;
      n_rst = 1'b0;
      #1;
      check("midrst_wen", {31'h0, rf_wen}, 32'd0);
      check("midrst_wsel", {27'h0, rf_wsel}, 32'd0);
      check("midrst_wdat", rf_wdat, 32'd0);
      check("midrst_fwd", {31'h0, fwd_valid}, 32'd0);
      cycles(1);
      n_rst = 1'b1;
      cycles(3);
      stall = 1'b0;
      cycles(2);
      check("midrst_retired", retired, 32'd0);

      // Writes resume with a fresh entry
      issue(1, 5'd15, 32'hF00D, 32'h0, 0, 3'd0, 2'd0, 0, 32'h0, 0, 1, 5'd15, 32'h0000_F00D);
      cycles(1);
      check("retired_resume", retired, 32'd1);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
